// File: rtl/mandelbrot_core.sv
// rtl/mandelbrot_core.sv - fixed-point Mandelbrot escape-time engine
//
// Iterates z <- z^2 + c from z = 0 for one latched point c = io_re + i*io_im
// and reports the number of z updates performed before |z|^2 > 4,
// saturating at ITER_MAX.
//
// Optional feature macro: MANDELBROT_TRACE_EN (prints cr, ci and the
// iteration count when a calculation completes; simulation only).
//
// Parameters:
//   FP_WIDTH  total signed fixed-point width
//   FP_INT    integer bits including sign (FRAC = FP_WIDTH - FP_INT)
//   ITER_MAX  iteration limit
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   io_start        begin a calculation (sampled only in IDLE)
//   io_re, io_im    signed fixed-point real / imaginary part of c
//   io_iter         iteration count, valid from io_done until the next start
//   io_calculating  high while a calculation is in progress
//   io_done         one-cycle completion pulse

module mandelbrot_core #(
  parameter int FP_WIDTH = 25,
  parameter int FP_INT   = 4,
  parameter int ITER_MAX = 255,
  localparam int ITERW   = $clog2(ITER_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       io_start,
  input  logic signed [FP_WIDTH-1:0] io_re,
  input  logic signed [FP_WIDTH-1:0] io_im,
  output logic [ITERW-1:0]           io_iter,
  output logic                       io_calculating,
  output logic                       io_done
);

  localparam int FRAC = FP_WIDTH - FP_INT;
  localparam int PW   = 2 * FP_WIDTH;

  // 4.0 expressed in the product scale (2*FRAC fractional bits).
  localparam logic signed [PW:0] ESC_LIMIT = (PW + 1)'(4) <<< (2 * FRAC);
  localparam logic [ITERW-1:0]   ITER_LIM  = ITERW'(ITER_MAX);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    CHECK,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [FP_WIDTH-1:0] cr;
  logic signed [FP_WIDTH-1:0] ci;
  logic signed [FP_WIDTH-1:0] x;
  logic signed [FP_WIDTH-1:0] y;
  logic signed [PW-1:0]       xx;
  logic signed [PW-1:0]       yy;
  logic signed [PW-1:0]       xy;
  logic [ITERW-1:0]           iter;

  logic signed [PW-1:0]       x_ext;
  logic signed [PW-1:0]       y_ext;
  logic signed [PW:0]         mag2;
  logic signed [PW:0]         diff;
  logic [PW:0]                xy2;
  logic signed [FP_WIDTH-1:0] x_next;
  logic signed [FP_WIDTH-1:0] y_next;
  logic                       escaped;
  logic                       at_limit;
  logic                       unused_bits;

  // Sign-extend before multiplying so the product is full width.
  assign x_ext = {{FP_WIDTH{x[FP_WIDTH-1]}}, x};
  assign y_ext = {{FP_WIDTH{y[FP_WIDTH-1]}}, y};

  // One extra bit keeps xx+yy and xx-yy free of overflow.
  assign mag2     = {xx[PW-1], xx} + {yy[PW-1], yy};
  assign diff     = {xx[PW-1], xx} - {yy[PW-1], yy};
  assign xy2      = {xy, 1'b0};
  assign escaped  = mag2 > ESC_LIMIT;
  assign at_limit = iter == ITER_LIM;

  // Taking bits [FRAC +: FP_WIDTH] is the arithmetic shift right by FRAC
  // followed by truncation; the add then wraps modulo 2^FP_WIDTH.
  assign x_next = diff[FRAC +: FP_WIDTH] + cr;
  assign y_next = xy2[FRAC +: FP_WIDTH] + ci;

  // Bits discarded by the fixed-point rescale.
  assign unused_bits = ^{diff[PW:FRAC+FP_WIDTH], diff[FRAC-1:0],
                         xy2[PW:FRAC+FP_WIDTH], xy2[FRAC-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    io_calculating = 1'b0;
    io_done        = 1'b0;
    case (state)
      IDLE: begin
        if (io_start) begin
          state_next = MUL;
        end
      end
      MUL: begin
        io_calculating = 1'b1;
        state_next     = CHECK;
      end
      CHECK: begin
        io_calculating = 1'b1;
        if (escaped || at_limit) begin
          state_next = DONE;
        end else begin
          state_next = MUL;
        end
      end
      DONE: begin
        io_done    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cr   <= '0;
      ci   <= '0;
      x    <= '0;
      y    <= '0;
      xx   <= '0;
      yy   <= '0;
      xy   <= '0;
      iter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_start) begin
            cr   <= io_re;
            ci   <= io_im;
            x    <= '0;
            y    <= '0;
            iter <= '0;
          end
        end
        MUL: begin
          xx <= x_ext * x_ext;
          yy <= y_ext * y_ext;
          xy <= x_ext * y_ext;
        end
        CHECK: begin
          if (!escaped && !at_limit) begin
            x    <= x_next;
            y    <= y_next;
            iter <= iter + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_iter = iter;

`ifdef MANDELBROT_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && state == CHECK && state_next == DONE) begin
      $display("mandelbrot: cr=%f ci=%f iter=%0d",
               $itor(cr) / (2.0 ** FRAC), $itor(ci) / (2.0 ** FRAC), iter);
    end
  end
`else
  // Trace output not compiled in.
`endif

endmodule

// File: tb/tb_mandelbrot_core.sv
// tb/tb_mandelbrot_core.sv - self-checking bench for mandelbrot_core

module tb_mandelbrot_core;

  localparam int W    = 25;
  localparam int FRAC = 21;
  localparam int ONE  = 1 << FRAC;

  logic                clk;
  logic                rst;
  logic [3:0]          start;
  logic signed [W-1:0] re [4];
  logic signed [W-1:0] im [4];
  logic [7:0]          iter [4];
  logic [3:0]          calc;
  logic [3:0]          done;

  int total;
  int bad;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mandelbrot_core dut (
      .clk            (clk),
      .rst            (rst),
      .io_start       (start[g]),
      .io_re          (re[g]),
      .io_im          (im[g]),
      .io_iter        (iter[g]),
      .io_calculating (calc[g]),
      .io_done        (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap25(input longint v);
    longint m;
    m = v & ((longint'(1) << W) - 1);
    if (m >= (longint'(1) << (W - 1))) m = m - (longint'(1) << W);
    return m;
  endfunction

  // Escape-time count computed directly from the iteration rules.
  function automatic int model_iter(input longint cr, input longint ci);
    longint zx, zy, sx, sy, nx;
    int n;
    zx = 0;
    zy = 0;
    n  = 0;
    while (1) begin
      sx = zx * zx;
      sy = zy * zy;
      if (sx + sy > (longint'(4) << (2 * FRAC))) return n;
      if (n == 255) return n;
      nx = wrap25(((sx - sy) >>> FRAC) + cr);
      zy = wrap25(((2 * zx * zy) >>> FRAC) + ci);
      zx = nx;
      n++;
    end
    return n;
  endfunction

  // Start instance 0 and wait for io_done; lat counts edges from the
  // start-sampling edge (lat=1) to the cycle where io_done is seen.
  task automatic run(input int r, input int i, output int lat, output int it,
                     output bit calc_ok);
    @(negedge clk);
    start[0] = 1'b1;
    re[0]    = W'(r);
    im[0]    = W'(i);
    lat      = -1;
    it       = -1;
    calc_ok  = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) start[0] = 1'b0;
      if (done[0]) begin
        lat = k;
        it  = int'(iter[0]);
        break;
      end
      if (!calc[0]) calc_ok = 1'b0;
    end
  endtask

  typedef struct {
    string name;
    int    re;
    int    im;
    int    exp_iter;
    int    exp_lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat, it, n_done, first_done;
    bit calc_ok;
    int lat4[4];
    int exp_it;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 4'b0;
    for (int j = 0; j < 4; j++) begin
      re[j] = '0;
      im[j] = '0;
    end

    tbl[0] = '{"c3_0",     3 * ONE,       0,       1,   5};
    tbl[1] = '{"c1_0",     ONE,           0,       3,   9};
    tbl[2] = '{"c0_0",     0,             0,       255, 513};
    tbl[3] = '{"cm2_0",    -2 * ONE,      0,       255, 513};
    tbl[4] = '{"c2_0",     2 * ONE,       0,       2,   7};
    tbl[5] = '{"c0_2i",    0,             2 * ONE, 2,   7};
    tbl[6] = '{"cm2p5_0",  -5 * ONE / 2,  0,       1,   5};
    tbl[7] = '{"cm1_0",    -ONE,          0,       255, 513};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_iter", iter[0], 0);
    chk("reset_done", done[0], 0);
    chk("reset_calc", calc[0], 0);

    // Table vectors, run back to back (each start lands in the first IDLE
    // cycle after the previous DONE).
    foreach (tbl[v]) begin
      run(tbl[v].re, tbl[v].im, lat, it, calc_ok);
      chk({tbl[v].name, "_iter"}, it, tbl[v].exp_iter);
      chk({tbl[v].name, "_lat"}, lat, tbl[v].exp_lat);
      chk({tbl[v].name, "_calc"}, calc_ok, 1);
    end

    // io_done lasts one cycle and io_iter holds afterwards.
    @(negedge clk);
    chk("done_one_cycle", done[0], 0);
    chk("iter_held", iter[0], 255);
    chk("calc_low_after", calc[0], 0);

    // Inputs changed and io_start pulsed mid-run and during DONE.
    @(negedge clk);
    start[0] = 1'b1;
    re[0] = W'(ONE);
    im[0] = '0;
    n_done = 0;
    first_done = -1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      case (k)
        1:  start[0] = 1'b0;
        2:  begin re[0] = W'(3 * ONE); im[0] = W'(ONE); start[0] = 1'b1; end
        3:  start[0] = 1'b0;
        8:  start[0] = 1'b1;
        10: start[0] = 1'b0;
        default: ;
      endcase
      if (done[0]) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (k == 9) chk("ignore_iter", iter[0], 3);
      if (k == 10) chk("ignore_iter_held", iter[0], 3);
    end
    chk("ignore_done_at", first_done, 9);
    chk("ignore_done_count", n_done, 1);

    // Reset in the middle of a c=(0,0) run.
    @(negedge clk);
    start[0] = 1'b1;
    re[0] = '0;
    im[0] = '0;
    n_done = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) start[0] = 1'b0;
      if (k == 3) rst = 1'b1;
      if (k == 4) begin
        chk("rst_calc", calc[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_iter", iter[0], 0);
        rst = 1'b0;
      end
      if (done[0]) n_done++;
    end
    chk("rst_no_done", n_done, 0);
    run(3 * ONE, 0, lat, it, calc_ok);
    chk("after_rst_iter", it, 1);
    chk("after_rst_lat", lat, 5);

    // Four instances started together at (+-0.25, +-0.25).
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      re[j] = W'((j[0] ? -1 : 1) * (ONE / 4));
      im[j] = W'((j[1] ? -1 : 1) * (ONE / 4));
      lat4[j] = -1;
    end
    start = 4'hF;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) start = 4'h0;
      for (int j = 0; j < 4; j++) begin
        if (done[j] && lat4[j] < 0) begin
          lat4[j] = k;
          chk($sformatf("quad%0d_iter", j), iter[j], 255);
        end
      end
      if (lat4[0] > 0 && lat4[1] > 0 && lat4[2] > 0 && lat4[3] > 0) break;
    end
    for (int j = 0; j < 4; j++) chk($sformatf("quad%0d_lat", j), lat4[j], 513);

    // Randomized points against the reference model.
    for (int n = 0; n < 20; n++) begin
      int r, i;
      r = int'($urandom_range(0, 5 * ONE)) - 5 * ONE / 2;
      i = int'($urandom_range(0, 3 * ONE)) - 3 * ONE / 2;
      exp_it = model_iter(longint'(r), longint'(i));
      run(r, i, lat, it, calc_ok);
      chk($sformatf("rand%0d_iter", n), it, exp_it);
      chk($sformatf("rand%0d_lat", n), lat, 2 * (exp_it + 1) + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
